// File: rtl/mmio_input_port.sv
// Memory-mapped input port: synchronised, debounced SW/KEY levels
// and sticky KEY press flags, returned for loads with one-cycle latency.
module mmio_input_port #(
    parameter int         SW_WIDTH        = 10,
    parameter int         KEY_WIDTH       = 4,
    parameter int         DATA_WIDTH      = 16,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [9:0] ADDR_SW         = 10'h3F8,
    parameter logic [9:0] ADDR_KEY        = 10'h3F9,
    parameter logic [9:0] ADDR_KEYEDGE    = 10'h3FA
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET,
    input  logic [SW_WIDTH-1:0]   I_SW,
    input  logic [KEY_WIDTH-1:0]  I_KEY,
    input  logic                  I_ReadEn,
    input  logic                  I_WriteEn,
    input  logic [9:0]            I_Addr,
    input  logic [DATA_WIDTH-1:0] I_WriteData,
    output logic [DATA_WIDTH-1:0] O_ReadData,
    output logic                  O_ReadHit,
    output logic                  O_KeyIrq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0]  sw_meta;
    logic [SW_WIDTH-1:0]  sw_sync;
    logic [SW_WIDTH-1:0]  sw_db;
    logic [CW-1:0]        sw_cnt [SW_WIDTH];

    logic [KEY_WIDTH-1:0] key_meta;
    logic [KEY_WIDTH-1:0] key_sync;
    logic [KEY_WIDTH-1:0] key_pressed;
    logic [KEY_WIDTH-1:0] key_db;
    logic [CW-1:0]        key_cnt [KEY_WIDTH];

    logic [KEY_WIDTH-1:0] key_rise;
    logic [KEY_WIDTH-1:0] edge_flags;
    logic [KEY_WIDTH-1:0] edge_clr;

    logic rd_sw;
    logic rd_key;
    logic rd_edge;
    logic wr_edge;
    logic unused_wdata;

    // Pins are active-low; internally 1 means pressed.
    assign key_pressed = ~key_sync;

    assign rd_sw   = I_ReadEn && (I_Addr == ADDR_SW);
    assign rd_key  = I_ReadEn && (I_Addr == ADDR_KEY);
    assign rd_edge = I_ReadEn && (I_Addr == ADDR_KEYEDGE);
    assign wr_edge = I_WriteEn && (I_Addr == ADDR_KEYEDGE);

    assign unused_wdata = ^I_WriteData[DATA_WIDTH-1:KEY_WIDTH];

    // A press edge is the cycle a debounced KEY bit is about to go 0->1.
    always_comb begin
        key_rise = '0;
        for (int i = 0; i < KEY_WIDTH; i++) begin
            key_rise[i] = key_pressed[i] && !key_db[i] &&
                          (key_cnt[i] == CNT_LAST);
        end
    end

    // Read-to-clear drops what is returned; W1C drops what is written.
    always_comb begin
        edge_clr = '0;
        if (rd_edge) begin
            edge_clr = edge_clr | edge_flags;
        end
        if (wr_edge) begin
            edge_clr = edge_clr | I_WriteData[KEY_WIDTH-1:0];
        end
    end

    // Two-flop synchronisers; KEY resets to released (pins high).
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '1;
            key_sync <= '1;
        end else begin
            sw_meta  <= I_SW;
            sw_sync  <= sw_meta;
            key_meta <= I_KEY;
            key_sync <= key_meta;
        end
    end

    // SW debounce: a bit follows its synced value only after a full stable run.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            sw_db <= '0;
            for (int i = 0; i < SW_WIDTH; i++) begin
                sw_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SW_WIDTH; i++) begin
                if (sw_sync[i] == sw_db[i]) begin
                    sw_cnt[i] <= '0;
                end else if (sw_cnt[i] == CNT_LAST) begin
                    sw_db[i]  <= sw_sync[i];
                    sw_cnt[i] <= '0;
                end else begin
                    sw_cnt[i] <= sw_cnt[i] + CW'(1);
                end
            end
        end
    end

    // KEY debounce, same scheme on the pressed-polarity value.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            key_db <= '0;
            for (int i = 0; i < KEY_WIDTH; i++) begin
                key_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
                if (key_pressed[i] == key_db[i]) begin
                    key_cnt[i] <= '0;
                end else if (key_cnt[i] == CNT_LAST) begin
                    key_db[i]  <= key_pressed[i];
                    key_cnt[i] <= '0;
                end else begin
                    key_cnt[i] <= key_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Sticky edge flags: a new press beats a same-cycle clear.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            edge_flags <= '0;
            O_KeyIrq   <= 1'b0;
        end else begin
            edge_flags <= (edge_flags & ~edge_clr) | key_rise;
            O_KeyIrq   <= |edge_flags;
        end
    end

    // Registered load response; data holds when no read is issued.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            O_ReadData <= '0;
            O_ReadHit  <= 1'b0;
        end else if (I_ReadEn) begin
            unique case (1'b1)
                rd_sw: begin
                    O_ReadData <= DATA_WIDTH'(sw_db);
                    O_ReadHit  <= 1'b1;
                end
                rd_key: begin
                    O_ReadData <= DATA_WIDTH'(key_db);
                    O_ReadHit  <= 1'b1;
                end
                rd_edge: begin
                    O_ReadData <= DATA_WIDTH'(edge_flags);
                    O_ReadHit  <= 1'b1;
                end
                default: begin
                    O_ReadData <= '0;
                    O_ReadHit  <= 1'b0;
                end
            endcase
        end else begin
            O_ReadHit <= 1'b0;
        end
    end

endmodule
